axi_rd_rr_scheduler: RTL and testbench
======================================

# axi_rd_rr_scheduler

Round-robin arbiter and outstanding-read tracker for the shared AR channel of the 4-way AXI read merger.
- Takes per-requester "AR entry pending" flags from the requester AR FIFOs and issues one-hot grants that hold steady until the downstream slave accepts.
- Counts outstanding bursts per requester and retires them on R-channel last-beat completions.
- Blocks any requester whose outstanding count reaches MAXOUT, so the per-port ID FIFOs cannot overflow.

## Interface
Parameters:
- NREQ, 4, number of requesters; grant_idx is 2 bits, so NREQ ≤ 4.
- MAXOUT, 8, maximum outstanding bursts per requester; must equal the ID FIFO depth.
- CNTW, 4, counter width; must satisfy 2^CNTW > MAXOUT.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  requester AR FIFO non-empty; held high until granted.
- arvalid  out  1  AR valid to the shared slave port.
- arready  in  1  AR ready from the slave.
- grant  out  NREQ  one-hot select of the winning requester; all zeros when idle.
- grant_idx  out  2  binary index of grant.
- done_vld  in  1  completion pulse (rvalid && rready && rlast) for one burst.
- done_idx  in  2  requester index of the completing burst.
- at_limit  out  NREQ  per-port flag: outstanding count == MAXOUT.
- err  out  1  sticky flag: completion arrived for a port with zero outstanding.
- hp  in  NREQ  high-priority request flags; present only with AXI_RD_SCHED_QOS_EN.

## Operation
- Per-port state: cnt[i] (CNTW bits), outstanding bursts.
- Round-robin state: ptr (2 bits), index of the last winner.
- Eligibility: elig[i] = req[i] && (cnt[i] < MAXOUT).
- Selection: the first eligible index scanning ptr+1, ptr+2, … (mod NREQ).

State machine, two states:
- IDLE: arvalid=0, grant=0.
  - If elig is non-zero, register the winner into grant/grant_idx and move to OFFER.
- OFFER: arvalid=1; grant is frozen while arready=0.
- On arready in OFFER:
  - cnt[winner] increments and ptr updates to the winner.
  - The arbiter re-selects in the same cycle using the post-increment count for the winner.
  - If any port is eligible, the new grant is registered and the block stays in OFFER; otherwise it returns to IDLE.

Counters:
- done_vld decrements cnt[done_idx].
- If the same port sees an increment and a decrement in the same cycle, its count is unchanged.
- done_vld with cnt[done_idx]==0: the counter stays at 0 and err is set. err clears only on rst.
- A counter never exceeds MAXOUT, because eligibility gates the grant.
- at_limit is decoded from the registered counts.

If req[winner] drops while in OFFER (a protocol violation), the grant is still held until arready.

## Timing
- Reset values: state=IDLE, arvalid=0, grant=0, grant_idx=0, all cnt=0, at_limit=0, err=0, ptr=NREQ-1 (port 0 wins first).
- Latency: a req rising in IDLE at cycle N gives arvalid=1 with the grant at cycle N+1.
- Back-to-back: arready at cycle M with another eligible request gives a new grant at M+1 with arvalid staying high (no bubble).
- Throughput: 1 grant per cycle.
- A completion at cycle M frees a blocked port for selection in the arbitration evaluated at M+1.
- Asserting rst mid-OFFER immediately drops arvalid and clears all counts and err. An in-flight slave transaction is abandoned.

## Configuration
- AXI_RD_SCHED_QOS_EN defined:
  - The hp port exists.
  - If (elig & hp) is non-zero, selection runs round-robin over (elig & hp) only.
  - Otherwise selection runs round-robin over elig.
  - ptr is shared across both classes.
- AXI_RD_SCHED_QOS_EN undefined: the hp port is absent and selection is plain round-robin over elig.

## Test plan
- Reset, then req=4'b1111 with arready=1 held → grant sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles; arvalid high from cycle 1 onward.
- req=4'b0100 with arready=0 for 5 cycles, then 1 → grant stable at 0100 and grant_idx=2 for all 6 cycles; cnt[2]=1 afterwards; return to IDLE.
- req[0] held with no completions → exactly 8 grants to port 0, then at_limit[0]=1 and arvalid=0. One done_vld with done_idx=0 → port 0 regranted 2 cycles later.
- cnt[1]=3; arready accepting port 1 in the same cycle as done_vld with done_idx=1 → cnt[1] remains 3.
- done_vld with done_idx=3 while cnt[3]=0 → err=1 persists and cnt[3] stays 0; rst asserted mid-OFFER → arvalid=0 and err=0 asynchronously.
- With AXI_RD_SCHED_QOS_EN, req=1111 and hp=0100 → port 2 is granted every cycle until hp drops or at_limit[2]; then round-robin resumes from ptr=2 (port 3 next).

Source files
------------

// File: rtl/axi_rd_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_rr_scheduler
// Purpose  : Round-robin AR-channel arbiter with per-requester outstanding-burst
//            tracking. Optional high-priority class: AXI_RD_SCHED_QOS_EN.
// Revision : 1.0
// ============================================================================
module axi_rd_rr_scheduler #(
  parameter int NREQ   = 4,
  parameter int MAXOUT = 8,
  parameter int CNTW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
`ifdef AXI_RD_SCHED_QOS_EN
  input  logic [NREQ-1:0] hp,
`endif
  output logic            arvalid,
  input  logic            arready,
  output logic [NREQ-1:0] grant,
  output logic [1:0]      grant_idx,
  input  logic            done_vld,
  input  logic [1:0]      done_idx,
  output logic [NREQ-1:0] at_limit,
  output logic            err
);

  localparam logic [CNTW-1:0] c_max_out = CNTW'(MAXOUT);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CNTW-1:0] r_cnt [NREQ];
  logic [CNTW-1:0] w_cnt_eval [NREQ];
  logic [1:0]      r_ptr;
  logic [1:0]      w_ptr_nxt;
  logic [1:0]      w_arb_ptr;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] w_grant_nxt;
  logic [1:0]      r_grant_idx;
  logic [1:0]      w_grant_idx_nxt;
  logic            r_err;
  logic            w_accept;
  logic [NREQ-1:0] w_inc;
  logic [NREQ-1:0] w_dec;
  logic            w_done_zero;
  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_mask;
  logic [3:0]      w_mask4;
  logic            w_sel_vld;
  logic [1:0]      w_sel_idx;
  int              w_scan;

  assign w_accept  = (r_state == S_OFFER) && arready;
  // On acceptance the just-served winner becomes the round-robin origin immediately.
  assign w_arb_ptr = w_accept ? r_grant_idx : r_ptr;

  always_comb begin
    w_done_zero = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      w_inc[i]      = w_accept && (r_grant_idx == 2'(i));
      w_dec[i]      = done_vld && (done_idx == 2'(i)) && (r_cnt[i] != '0);
      w_cnt_eval[i] = r_cnt[i] + (w_inc[i] ? CNTW'(1) : CNTW'(0));
      w_elig[i]     = req[i] && (w_cnt_eval[i] < c_max_out);
      if (done_vld && (done_idx == 2'(i)) && (r_cnt[i] == '0)) begin
        w_done_zero = 1'b1;
      end
    end
  end

`ifdef AXI_RD_SCHED_QOS_EN
  assign w_mask = ((w_elig & hp) != '0) ? (w_elig & hp) : w_elig;
`else
  assign w_mask = w_elig;
`endif

  // Scan from farthest to nearest so the nearest eligible index after the pointer wins.
  always_comb begin
    w_mask4             = 4'b0000;
    w_mask4[NREQ-1:0]   = w_mask;
    w_sel_vld           = 1'b0;
    w_sel_idx           = 2'd0;
    w_scan              = 0;
    for (int k = NREQ; k >= 1; k--) begin
      w_scan = (int'(w_arb_ptr) + k) % NREQ;
      if (w_mask4[w_scan[1:0]]) begin
        w_sel_vld = 1'b1;
        w_sel_idx = w_scan[1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_grant_idx_nxt = r_grant_idx;
    w_ptr_nxt       = w_accept ? r_grant_idx : r_ptr;
    if ((r_state == S_IDLE) || w_accept) begin
      if (w_sel_vld) begin
        w_state_nxt     = S_OFFER;
        w_grant_nxt     = NREQ'(1) << w_sel_idx;
        w_grant_idx_nxt = w_sel_idx;
      end else begin
        w_state_nxt     = S_IDLE;
        w_grant_nxt     = '0;
        w_grant_idx_nxt = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_grant_idx <= 2'd0;
      r_ptr       <= 2'(NREQ - 1);
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_grant_idx <= w_grant_idx_nxt;
      r_ptr       <= w_ptr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        r_cnt[i] <= '0;
      end
      r_err <= 1'b0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_inc[i] && !w_dec[i]) begin
          r_cnt[i] <= r_cnt[i] + CNTW'(1);
        end else if (!w_inc[i] && w_dec[i]) begin
          r_cnt[i] <= r_cnt[i] - CNTW'(1);
        end
      end
      if (w_done_zero) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      at_limit[i] = (r_cnt[i] == c_max_out);
    end
  end

  assign arvalid   = (r_state == S_OFFER);
  assign grant     = r_grant;
  assign grant_idx = r_grant_idx;
  assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_axi_rd_rr_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_axi_rd_rr_scheduler
// Purpose  : Self-checking bench: directed scenarios plus a per-cycle
//            behavioural model of the round-robin scheduler.
// Revision : 1.0
// ============================================================================
module tb_axi_rd_rr_scheduler;

  localparam int NREQ   = 4;
  localparam int MAXOUT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
`ifdef AXI_RD_SCHED_QOS_EN
  logic [3:0] hp;
`endif
  logic       arready;
  logic       done_vld;
  logic [1:0] done_idx;
  logic       arvalid;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic [3:0] at_limit;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axi_rd_rr_scheduler #(.NREQ(NREQ), .MAXOUT(MAXOUT), .CNTW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
`ifdef AXI_RD_SCHED_QOS_EN
    .hp       (hp),
`endif
    .arvalid  (arvalid),
    .arready  (arready),
    .grant    (grant),
    .grant_idx(grant_idx),
    .done_vld (done_vld),
    .done_idx (done_idx),
    .at_limit (at_limit),
    .err      (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: outstanding counts, last winner, and the burst on offer.
  int m_cnt [4];
  int m_ptr;
  bit m_offer;
  int m_gidx;
  bit m_err;

  function automatic int pick(input logic [3:0] mask, input int base);
    int idx;
    for (int k = 1; k <= 4; k++) begin
      idx = (base + k) % 4;
      if (mask[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit         acc;
    int         win;
    int         ce;
    logic [3:0] elig;
    logic [3:0] mask;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_ptr   = NREQ - 1;
      m_offer = 1'b0;
      m_gidx  = 0;
      m_err   = 1'b0;
    end else begin
      acc = m_offer && arready;
      for (int i = 0; i < 4; i++) begin
        ce      = m_cnt[i] + ((acc && m_gidx == i) ? 1 : 0);
        elig[i] = req[i] && (ce < MAXOUT);
      end
      mask = elig;
`ifdef AXI_RD_SCHED_QOS_EN
      if ((elig & hp) != 4'b0000) mask = elig & hp;
`endif
      win = pick(mask, acc ? m_gidx : m_ptr);
      if (done_vld) begin
        if (m_cnt[done_idx] == 0) m_err = 1'b1;
        else m_cnt[done_idx] = m_cnt[done_idx] - 1;
      end
      if (acc) begin
        m_cnt[m_gidx] = m_cnt[m_gidx] + 1;
        m_ptr         = m_gidx;
      end
      if (!m_offer || acc) begin
        if (win >= 0) begin
          m_offer = 1'b1;
          m_gidx  = win;
        end else begin
          m_offer = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [3:0] exp_lim;
    if (!rst) begin
      for (int i = 0; i < 4; i++) exp_lim[i] = (m_cnt[i] == MAXOUT);
      chk("model_arvalid", 32'(arvalid), 32'(m_offer));
      chk("model_grant", 32'(grant), m_offer ? 32'(4'b0001 << m_gidx) : 32'd0);
      if (m_offer) chk("model_grant_idx", 32'(grant_idx), 32'(m_gidx));
      chk("model_at_limit", 32'(at_limit), 32'(exp_lim));
      chk("model_err", 32'(err), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req      = 4'b0000;
`ifdef AXI_RD_SCHED_QOS_EN
    hp       = 4'b0000;
`endif
    arready  = 1'b0;
    done_vld = 1'b0;
    done_idx = 2'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [3:0] rr_exp [5];
  int         n_acc;

  initial begin
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

    // Reset values
    do_reset();
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_grant_idx", 32'(grant_idx), 32'd0);
    chk("rst_at_limit", 32'(at_limit), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // All requesting, slave always ready: one grant per cycle in rotation
    req = 4'b1111; arready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_grant", 32'(grant), 32'(rr_exp[i]));
      chk("rr_arvalid", 32'(arvalid), 32'd1);
    end
    req = 4'b0000;
    tick();
    chk("rr_idle_arvalid", 32'(arvalid), 32'd0);

    // Grant frozen while the slave stalls
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("hold_grant", 32'(grant), 32'h4);
      chk("hold_idx", 32'(grant_idx), 32'd2);
    end
    arready = 1'b1; req = 4'b0000;
    tick();
    chk("hold_idle_arvalid", 32'(arvalid), 32'd0);
    chk("hold_idle_grant", 32'(grant), 32'd0);
    chk("hold_cnt2", 32'(dut.r_cnt[2]), 32'd1);

    // Outstanding limit on port 0, then release by one completion
    do_reset();
    req = 4'b0001; arready = 1'b1; n_acc = 0;
    for (int i = 0; i < 12; i++) begin
      if (arvalid === 1'b1 && arready) n_acc++;
      tick();
    end
    chk("limit_grants", 32'(n_acc), 32'd8);
    chk("limit_arvalid", 32'(arvalid), 32'd0);
    chk("limit_at_limit", 32'(at_limit), 32'h1);
    done_vld = 1'b1; done_idx = 2'd0;
    tick();
    done_vld = 1'b0;
    chk("release_arvalid_m", 32'(arvalid), 32'd0);
    chk("release_at_limit", 32'(at_limit), 32'h0);
    tick();
    chk("release_arvalid_m1", 32'(arvalid), 32'd1);
    chk("release_grant", 32'(grant), 32'h1);

    // Simultaneous accept and completion on port 1 leaves its count unchanged
    do_reset();
    req = 4'b0010; arready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("same_cnt_before", 32'(dut.r_cnt[1]), 32'd3);
    done_vld = 1'b1; done_idx = 2'd1;
    tick();
    done_vld = 1'b0;
    chk("same_cnt_after", 32'(dut.r_cnt[1]), 32'd3);
    chk("same_err", 32'(err), 32'd0);

    // Completion with nothing outstanding, then asynchronous reset mid-offer
    do_reset();
    done_vld = 1'b1; done_idx = 2'd3;
    tick();
    done_vld = 1'b0;
    chk("err_set", 32'(err), 32'd1);
    chk("err_cnt3", 32'(dut.r_cnt[3]), 32'd0);
    tick(); tick();
    chk("err_sticky", 32'(err), 32'd1);
    req = 4'b0001;
    tick();
    chk("offer_before_rst", 32'(arvalid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_arvalid", 32'(arvalid), 32'd0);
    chk("async_rst_err", 32'(err), 32'd0);
    chk("async_rst_cnt0", 32'(dut.r_cnt[0]), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; req = 4'b0000;

    // Mixed traffic checked only by the model
    do_reset();
    for (int c = 0; c < 60; c++) begin
      req      = 4'($urandom_range(0, 15));
      arready  = 1'($urandom_range(0, 1));
      done_vld = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        int d;
        d = $urandom_range(0, 3);
        if (m_cnt[d] > 0) begin
          done_vld = 1'b1;
          done_idx = 2'(d);
        end
      end
      tick();
    end

`ifdef AXI_RD_SCHED_QOS_EN
    // High-priority port monopolises until it hits its limit
    do_reset();
    req = 4'b1111; hp = 4'b0100; arready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("qos_grant", 32'(grant), 32'h4);
    end
    tick();
    chk("qos_after_limit_grant", 32'(grant), 32'h8);
    chk("qos_at_limit", 32'(at_limit), 32'h4);
`endif

    do_reset();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
